// File: rtl/rocket_pkg.sv
// Shared constants for the rocket-thrust mass-ratio solver: ln tables in Q.16 and FSM encoding.
package rocket_pkg;

    localparam logic [19:0] LN2_Q16 = 20'd45426;
    localparam logic [16:0] Q16_ONE = 17'h10000;
    // Extra fraction bits carried by the exp accumulator below the Q.16 result.
    localparam int          Y_GUARD = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_RANGE,
        S_EXP,
        S_MUL,
        S_DONE
    } state_t;

    // L[i] = round(-ln(1 - 2^-i) * 65536)
    function automatic logic [19:0] ln_tab(input logic [4:0] i);
        logic [19:0] l;
        case (i)
            5'd1:    l = 20'd45426;
            5'd2:    l = 20'd18854;
            5'd3:    l = 20'd8751;
            5'd4:    l = 20'd4230;
            5'd5:    l = 20'd2081;
            5'd6:    l = 20'd1032;
            5'd7:    l = 20'd514;
            5'd8:    l = 20'd257;
            5'd9:    l = 20'd128;
            5'd10:   l = 20'd64;
            5'd11:   l = 20'd32;
            5'd12:   l = 20'd16;
            5'd13:   l = 20'd8;
            5'd14:   l = 20'd4;
            5'd15:   l = 20'd2;
            5'd16:   l = 20'd1;
            default: l = 20'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/fix_div_serial.sv
// Restoring serial divider: one quotient bit per cycle, remainder discarded.
module fix_div_serial #(
    parameter int DEND_W = 52,
    parameter int DSOR_W = 32,
    parameter int Q_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DEND_W-1:0] dividend,
    input  logic [DSOR_W-1:0] divisor,
    output logic              done,
    output logic [Q_W-1:0]    quotient
);
    localparam int CNT_W = $clog2(Q_W + 1);

    logic              run;
    logic [CNT_W-1:0]  cnt;
    logic [DSOR_W-1:0] rem;
    logic [DSOR_W-1:0] dsor;
    logic [Q_W-1:0]    dq;
    logic [DSOR_W:0]   trial;
    logic              qbit;

    // Caller guarantees the quotient fits Q_W bits, so the top slice starts below the divisor.
    assign trial    = {rem, dq[Q_W-1]};
    assign qbit     = trial >= {1'b0, dsor};
    assign quotient = dq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run  <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            run  <= 1'b1;
            done <= 1'b0;
            cnt  <= CNT_W'(Q_W);
        end else if (run) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem  <= dividend[DEND_W-1:Q_W];
            dq   <= dividend[Q_W-1:0];
            dsor <= divisor;
        end else if (run) begin
            rem <= qbit ? DSOR_W'(trial - {1'b0, dsor}) : DSOR_W'(trial);
            dq  <= {dq[Q_W-2:0], qbit};
        end
    end

endmodule

// File: rtl/mass_ratio_solver.sv
// Mass ratio mu = exp(-dv/u') and propellant mass mp = m0*(1-mu) via serial divide
// and shift-and-add exponential, driven by a start/done handshake.
module mass_ratio_solver
    import rocket_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 4,
    parameter int XMAX   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       dv_milli,
    input  logic [31:0]       u_milli,
    input  logic [31:0]       m0_milli,
    output logic              busy,
    output logic              done,
    output logic [FRAC_W:0]   mu_q16,
    output logic [31:0]       mp_milli,
    output logic              uflow,
    output logic              err
);
    localparam int X_W    = INT_W + FRAC_W;
    localparam int MU_W   = FRAC_W + 1;
    localparam int Y_W    = MU_W + Y_GUARD;
    localparam int DEND_W = 32 + FRAC_W + INT_W;
    localparam logic [Y_W-1:0] Y_ONE = {1'b1, {(Y_W-1){1'b0}}};

    state_t          state;
    logic [31:0]     dv_r;
    logic [31:0]     u_r;
    logic [31:0]     m0_r;
    logic [X_W-1:0]  z;
    logic [Y_W-1:0]  y;
    logic [4:0]      i_r;
    logic [4:0]      k_r;

    logic [35:0]     u_lim;
    logic            over_lim;
    logic            div_start;
    logic            div_done;
    logic [X_W-1:0]  div_q;
    logic [DEND_W-1:0] div_dend;
    logic [19:0]     l_i;
    logic            range_sub;
    logic            exp_sub;
    logic [MU_W-1:0] mu_next;

    function automatic logic [MU_W-1:0] mu_scale(input logic [Y_W-1:0] yv, input logic [4:0] kv);
        return MU_W'(yv >> (32'(kv) + Y_GUARD));
    endfunction

    // m0*(1-mu) truncated; product never exceeds 48 bits since (1-mu) <= 2^16.
    function automatic logic [31:0] mp_trunc(input logic [31:0] m0, input logic [MU_W-1:0] mu);
        logic [47:0] p;
        p = 48'(m0) * 48'(Q16_ONE - mu);
        return 32'(p >> FRAC_W);
    endfunction

    assign u_lim     = 36'(u_r) * 36'(XMAX);
    assign over_lim  = {4'b0, dv_r} >= u_lim;
    assign div_start = (state == S_CHECK) && (u_r != 32'd0) && !over_lim;
    assign div_dend  = DEND_W'(dv_r) << FRAC_W;
    assign l_i       = ln_tab(i_r);
    assign range_sub = z >= LN2_Q16;
    assign exp_sub   = z >= l_i;
    assign mu_next   = (err || uflow) ? '0 : mu_scale(y, k_r);

    fix_div_serial #(
        .DEND_W (DEND_W),
        .DSOR_W (32),
        .Q_W    (X_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dend),
        .divisor  (u_r),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mu_q16   <= '0;
            mp_milli <= '0;
            uflow    <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        uflow <= 1'b0;
                        err   <= 1'b0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (u_r == 32'd0) begin
                        err   <= 1'b1;
                        state <= S_MUL;
                    end else if (over_lim) begin
                        uflow <= 1'b1;
                        state <= S_MUL;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_DIV:   if (div_done) state <= S_RANGE;
                S_RANGE: if (!range_sub) state <= S_EXP;
                S_EXP:   if (!exp_sub && i_r == 5'd16) state <= S_MUL;
                S_MUL: begin
                    mu_q16   <= mu_next;
                    mp_milli <= err ? 32'd0 : mp_trunc(m0_r, mu_next);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM decides when their contents matter.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    dv_r <= dv_milli;
                    u_r  <= u_milli;
                    m0_r <= m0_milli;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    z   <= div_q;
                    k_r <= 5'd0;
                end
            end
            S_RANGE: begin
                if (range_sub) begin
                    z   <= z - LN2_Q16;
                    k_r <= k_r + 5'd1;
                end else begin
                    i_r <= 5'd1;
                    y   <= Y_ONE;
                end
            end
            S_EXP: begin
                if (exp_sub) begin
                    z <= z - l_i;
                    y <= y - (y >> i_r);
                end else begin
                    i_r <= i_r + 5'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mass_ratio_solver.sv
// Self-checking bench for mass_ratio_solver: directed corner cases plus a random sweep
// compared against a real-valued exp() model.
module tb_mass_ratio_solver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dv_milli;
    logic [31:0] u_milli;
    logic [31:0] m0_milli;
    logic        busy;
    logic        done;
    logic [16:0] mu_q16;
    logic [31:0] mp_milli;
    logic        uflow;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mass_ratio_solver dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dv_milli (dv_milli),
        .u_milli  (u_milli),
        .m0_milli (m0_milli),
        .busy     (busy),
        .done     (done),
        .mu_q16   (mu_q16),
        .mp_milli (mp_milli),
        .uflow    (uflow),
        .err      (err)
    );

    task automatic check(input string tag, input real obs, input real exp, input real tol);
        n_cmp++;
        if ((obs - exp) > tol || (exp - obs) > tol) begin
            n_bad++;
            $display("FAIL %s: got %0.2f, want %0.2f (tol %0.2f)", tag, obs, exp, tol);
        end
    endtask

    function automatic real mu_model(input logic [31:0] dv, input logic [31:0] u);
        return $exp(-real'(dv) / real'(u)) * 65536.0;
    endfunction

    function automatic real mp_model(input logic [31:0] dv, input logic [31:0] u, input logic [31:0] m0);
        return real'(m0) * (1.0 - $exp(-real'(dv) / real'(u)));
    endfunction

    task automatic run_op(input logic [31:0] dv, input logic [31:0] u, input logic [31:0] m0,
                          output int lat);
        @(negedge clk);
        dv_milli = dv;
        u_milli  = u;
        m0_milli = m0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 0.0, 1.0, 0.0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;
        logic [31:0] u;
        logic [31:0] dv;
        logic [31:0] m0;
        int xm;

        reset = 1'b1;
        start = 1'b0;
        dv_milli = '0;
        u_milli  = '0;
        m0_milli = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  real'(busy),     0.0, 0.0);
        check("rst_done",  real'(done),     0.0, 0.0);
        check("rst_mu",    real'(mu_q16),   0.0, 0.0);
        check("rst_mp",    real'(mp_milli), 0.0, 0.0);
        check("rst_uflow", real'(uflow),    0.0, 0.0);
        check("rst_err",   real'(err),      0.0, 0.0);
        reset = 1'b0;

        // dv = 0: mu exactly one, no propellant
        run_op(32'd0, 32'd2577137, 32'd3233500000, lat);
        check("zero_dv_mu",    real'(mu_q16),   65536.0, 0.0);
        check("zero_dv_mp",    real'(mp_milli), 0.0, 0.0);
        check("zero_dv_uflow", real'(uflow),    0.0, 0.0);
        check("zero_dv_lat",   (lat <= 72) ? 1.0 : 0.0, 1.0, 0.0);

        // x = 1.0
        run_op(32'd2577137, 32'd2577137, 32'd1000000, lat);
        check("x1_mu", real'(mu_q16), mu_model(32'd2577137, 32'd2577137), 4.0);
        check("x1_mu_const", real'(mu_q16), 24109.0, 4.0);

        // Saturn V first stage
        run_op(32'd2649780, 32'd2577137, 32'd3233500000, lat);
        check("saturn_mu", real'(mu_q16), 23439.0, 4.0);
        check("saturn_mp", real'(mp_milli), 2077000000.0, 207700.0);

        // underflow at exactly 12*u
        run_op(32'd30925644, 32'd2577137, 32'd3233500000, lat);
        check("uflow_flag", real'(uflow),    1.0, 0.0);
        check("uflow_err",  real'(err),      0.0, 0.0);
        check("uflow_mu",   real'(mu_q16),   0.0, 0.0);
        check("uflow_mp",   real'(mp_milli), 3233500000.0, 0.0);
        check("uflow_lat",  real'(lat),      3.0, 0.0);

        // zero exhaust velocity
        run_op(32'd1000, 32'd0, 32'd3233500000, lat);
        check("err_flag",  real'(err),      1.0, 0.0);
        check("err_uflow", real'(uflow),    0.0, 0.0);
        check("err_mu",    real'(mu_q16),   0.0, 0.0);
        check("err_mp",    real'(mp_milli), 0.0, 0.0);
        check("err_lat",   real'(lat),      3.0, 0.0);

        // start re-pulsed while busy, and again in the DONE cycle
        @(negedge clk);
        dv_milli = 32'd2577137;
        u_milli  = 32'd2577137;
        m0_milli = 32'd1000000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", real'(busy), 1.0, 0.0);
        repeat (8) @(negedge clk);
        dv_milli = 32'd0;
        u_milli  = 32'd5;
        m0_milli = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("repulse_timeout", 0.0, 1.0, 0.0);
        check("repulse_mu", real'(mu_q16), mu_model(32'd2577137, 32'd2577137), 4.0);
        check("repulse_mp", real'(mp_milli), mp_model(32'd2577137, 32'd2577137, 32'd1000000), 80.0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", real'(busy), 0.0, 0.0);
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("done_start_ignored", real'(dones), 0.0, 0.0);
        check("result_held", real'(mu_q16), mu_model(32'd2577137, 32'd2577137), 4.0);

        // asynchronous reset in the middle of the exponential
        @(negedge clk);
        dv_milli = 32'd2577137;
        u_milli  = 32'd2577137;
        m0_milli = 32'd1000000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", real'(busy),     0.0, 0.0);
        check("midrst_done", real'(done),     0.0, 0.0);
        check("midrst_mu",   real'(mu_q16),   0.0, 0.0);
        check("midrst_mp",   real'(mp_milli), 0.0, 0.0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd2649780, 32'd2577137, 32'd3233500000, lat);
        check("after_rst_mu", real'(mu_q16), 23439.0, 4.0);
        check("after_rst_mp", real'(mp_milli), 2077000000.0, 207700.0);

        // random sweep
        for (int n = 0; n < 1000; n++) begin
            u  = (n % 7 == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom_range(1, 300000000));
            m0 = $urandom;
            if (n % 10 == 9) begin
                dv = 32'(longint'(u) * 12 + longint'($urandom_range(0, 200000000)));
                run_op(dv, u, m0, lat);
                check("rnd_uflow_flag", real'(uflow),    1.0, 0.0);
                check("rnd_uflow_mu",   real'(mu_q16),   0.0, 0.0);
                check("rnd_uflow_mp",   real'(mp_milli), real'(m0), 0.0);
            end else begin
                xm = $urandom_range(0, 11999);
                dv = 32'((longint'(u) * longint'(xm)) / 1000);
                run_op(dv, u, m0, lat);
                check("rnd_mu",    real'(mu_q16), mu_model(dv, u), 4.0);
                check("rnd_mp",    real'(mp_milli), mp_model(dv, u, m0),
                      real'(m0) * 4.5 / 65536.0 + 1.0);
                check("rnd_uflow", real'(uflow), 0.0, 0.0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
